// File: rtl/branch_predictor.sv
// IF-stage direct-mapped BTB with 2-bit saturating counters, trained from EX-stage resolution.
// Define BRANCH_PREDICTOR_STATS_EN to add the br_count / mispredict_count statistics ports.
module branch_predictor #(
   parameter int ENTRY_NUM = 16,
   parameter int INDEX_W   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] PC_IF,
   output logic        predict_taken_IF,
   output logic [31:0] predict_target_IF,
   input  logic        br_EX,
   input  logic        br_taken_EX,
   input  logic [31:0] br_target_EX,
   input  logic [31:0] PC_EX,
   input  logic        predict_taken_EX,
   output logic        mispredict_EX,
   output logic [31:0] redirect_PC_EX
`ifdef BRANCH_PREDICTOR_STATS_EN
   ,
   output logic [31:0] br_count,
   output logic [31:0] mispredict_count
`endif
);

   localparam int TAG_W = 32 - INDEX_W - 2;

   logic             valid_q  [ENTRY_NUM];
   logic [TAG_W-1:0] tag_q    [ENTRY_NUM];
   logic [31:0]      target_q [ENTRY_NUM];
   logic [1:0]       ctr_q    [ENTRY_NUM];

   logic [INDEX_W-1:0] lk_idx;
   logic [TAG_W-1:0]   lk_tag;
   logic               lk_hit;

   logic [INDEX_W-1:0] upd_idx;
   logic [TAG_W-1:0]   upd_tag;
   logic               upd_hit;
   logic               upd_we;
   logic [1:0]         ctr_d;
   logic [31:0]        target_d;

   // Word-alignment bits carry no information for indexing or tagging.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{PC_IF[1:0], PC_EX[1:0]};

   // Lookup reads the registered arrays directly, so a same-cycle update is not visible yet.
   assign lk_idx            = PC_IF[INDEX_W+1:2];
   assign lk_tag            = PC_IF[31:INDEX_W+2];
   assign lk_hit            = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign predict_taken_IF  = lk_hit && ctr_q[lk_idx][1];
   assign predict_target_IF = predict_taken_IF ? target_q[lk_idx] : PC_IF + 32'd4;

   assign mispredict_EX  = br_EX && (br_taken_EX != predict_taken_EX);
   assign redirect_PC_EX = (br_EX && br_taken_EX) ? br_target_EX : PC_EX + 32'd4;

   assign upd_idx = PC_EX[INDEX_W+1:2];
   assign upd_tag = PC_EX[31:INDEX_W+2];
   assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
   // A not-taken branch that misses leaves the table untouched.
   assign upd_we  = br_EX && (upd_hit || br_taken_EX);

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs; otherwise a latch is inferred.
      ctr_d    = ctr_q[upd_idx];
      target_d = target_q[upd_idx];
      if (!upd_hit) begin
         ctr_d    = 2'b10;
         target_d = br_target_EX;
      end else if (br_taken_EX) begin
         if (ctr_q[upd_idx] != 2'b11) ctr_d = ctr_q[upd_idx] + 2'd1;
         target_d = br_target_EX;
      end else begin
         if (ctr_q[upd_idx] != 2'b00) ctr_d = ctr_q[upd_idx] - 2'd1;
      end
   end

   // NOTE: the table is reset entry by entry because a cold BTB must never hit on stale
   // tags; this rules out a RAM macro, which is acceptable at these entry counts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRY_NUM; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
      end else if (upd_we) begin
         // NOTE: non-blocking so every flop samples pre-edge values, matching hardware.
         valid_q[upd_idx]  <= 1'b1;
         tag_q[upd_idx]    <= upd_tag;
         target_q[upd_idx] <= target_d;
         ctr_q[upd_idx]    <= ctr_d;
      end
   end

`ifdef BRANCH_PREDICTOR_STATS_EN
   logic [31:0] br_count_q, br_count_d;
   logic [31:0] mispredict_count_q, mispredict_count_d;

   assign br_count_d         = br_EX ? br_count_q + 32'd1 : br_count_q;
   assign mispredict_count_d = mispredict_EX ? mispredict_count_q + 32'd1 : mispredict_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_count_q         <= '0;
         mispredict_count_q <= '0;
      end else begin
         br_count_q         <= br_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   assign br_count         = br_count_q;
   assign mispredict_count = mispredict_count_q;
`else
   // Statistics counters compiled out.
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default and BRANCH_PREDICTOR_STATS_EN builds).
module tb_branch_predictor;

   logic        clk;
   logic        rst_n;
   logic [31:0] PC_IF;
   logic        predict_taken_IF;
   logic [31:0] predict_target_IF;
   logic        br_EX;
   logic        br_taken_EX;
   logic [31:0] br_target_EX;
   logic [31:0] PC_EX;
   logic        predict_taken_EX;
   logic        mispredict_EX;
   logic [31:0] redirect_PC_EX;
`ifdef BRANCH_PREDICTOR_STATS_EN
   logic [31:0] br_count;
   logic [31:0] mispredict_count;
   int unsigned exp_br;
   int unsigned exp_misp;
`endif

   int pass_cnt;
   int total_cnt;

   branch_predictor #(.ENTRY_NUM(16), .INDEX_W(4)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .PC_IF             (PC_IF),
      .predict_taken_IF  (predict_taken_IF),
      .predict_target_IF (predict_target_IF),
      .br_EX             (br_EX),
      .br_taken_EX       (br_taken_EX),
      .br_target_EX      (br_target_EX),
      .PC_EX             (PC_EX),
      .predict_taken_EX  (predict_taken_EX),
      .mispredict_EX     (mispredict_EX),
      .redirect_PC_EX    (redirect_PC_EX)
`ifdef BRANCH_PREDICTOR_STATS_EN
      ,
      .br_count          (br_count),
      .mispredict_count  (mispredict_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One EX-stage update: driven after a falling edge, committed on the next rising edge.
   task automatic update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                         input logic pred);
      @(negedge clk);
      PC_EX = pc; br_taken_EX = taken; br_target_EX = tgt; predict_taken_EX = pred;
      br_EX = 1'b1;
      @(posedge clk);
`ifdef BRANCH_PREDICTOR_STATS_EN
      exp_br++;
      if (taken != pred) exp_misp++;
`endif
      #1 br_EX = 1'b0;
   endtask

   task automatic lookup(input logic [31:0] pc, input logic exp_taken, input logic [31:0] exp_tgt,
                         input string name);
      @(negedge clk);
      PC_IF = pc;
      #1;
      total_cnt++;
      if (predict_taken_IF !== exp_taken) $display("FAIL %s taken: got %b expected %b", name, predict_taken_IF, exp_taken);
      else pass_cnt++;
      total_cnt++;
      if (predict_target_IF !== exp_tgt) $display("FAIL %s target: got %h expected %h", name, predict_target_IF, exp_tgt);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; br_EX = 1'b0; br_taken_EX = 1'b1; predict_taken_EX = 1'b0;
      br_target_EX = 32'h0000_0abc; PC_EX = 32'h0000_0300; PC_IF = 32'h0000_0100;
`ifdef BRANCH_PREDICTOR_STATS_EN
      exp_br = 0; exp_misp = 0;
`endif
      #12;
      total_cnt++;
      if (predict_taken_IF !== 1'b0) $display("FAIL reset_taken: got %b expected 0", predict_taken_IF);
      else pass_cnt++;
      total_cnt++;
      if (mispredict_EX !== 1'b0) $display("FAIL idle_mispredict: got %b expected 0", mispredict_EX);
      else pass_cnt++;
      total_cnt++;
      if (redirect_PC_EX !== 32'h0000_0304) $display("FAIL idle_redirect: got %h expected 00000304", redirect_PC_EX);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      lookup(32'h0000_0100, 1'b0, 32'h0000_0104, "cold_start");
   endtask

   task automatic test_allocation();
      @(negedge clk);
      PC_IF = 32'h0000_0100;
      PC_EX = 32'h0000_0100; br_taken_EX = 1'b1; br_target_EX = 32'h0000_0040; predict_taken_EX = 1'b0;
      br_EX = 1'b1;
      #1;
      total_cnt++;
      if (mispredict_EX !== 1'b1) $display("FAIL alloc_mispredict: got %b expected 1", mispredict_EX);
      else pass_cnt++;
      total_cnt++;
      if (redirect_PC_EX !== 32'h0000_0040) $display("FAIL alloc_redirect: got %h expected 00000040", redirect_PC_EX);
      else pass_cnt++;
      @(posedge clk);
`ifdef BRANCH_PREDICTOR_STATS_EN
      exp_br++; exp_misp++;
`endif
      #1 br_EX = 1'b0;
      lookup(32'h0000_0100, 1'b1, 32'h0000_0040, "alloc_hit");
   endtask

   task automatic test_hysteresis();
      // ctr 2 -> 1: not-taken prediction, target falls back to PC+4.
      update(32'h0000_0100, 1'b0, 32'h0000_0040, 1'b1);
      lookup(32'h0000_0100, 1'b0, 32'h0000_0104, "hyst_weak_nt");
      update(32'h0000_0100, 1'b1, 32'h0000_0040, 1'b0);
      update(32'h0000_0100, 1'b1, 32'h0000_0040, 1'b1);
      update(32'h0000_0100, 1'b1, 32'h0000_0080, 1'b1);
      lookup(32'h0000_0100, 1'b1, 32'h0000_0080, "hyst_strong_t");
      // Saturated at 3, one not-taken leaves it at 2: still predicted taken, target kept.
      update(32'h0000_0100, 1'b0, 32'h0000_0999, 1'b1);
      lookup(32'h0000_0100, 1'b1, 32'h0000_0080, "hyst_sat_high");
      // 2 -> 1 -> 0 -> 0, then one taken gives 1: still not taken if 0 saturated.
      update(32'h0000_0100, 1'b0, 32'h0, 1'b1);
      update(32'h0000_0100, 1'b0, 32'h0, 1'b0);
      update(32'h0000_0100, 1'b0, 32'h0, 1'b0);
      update(32'h0000_0100, 1'b1, 32'h0000_0088, 1'b0);
      lookup(32'h0000_0100, 1'b0, 32'h0000_0104, "hyst_sat_low");
      update(32'h0000_0100, 1'b1, 32'h0000_008c, 1'b0);
      lookup(32'h0000_0100, 1'b1, 32'h0000_008c, "hyst_recover");
   endtask

   task automatic test_alias();
      update(32'h0000_0140, 1'b1, 32'h0000_0060, 1'b0);
      lookup(32'h0000_0100, 1'b0, 32'h0000_0104, "alias_evicted");
      lookup(32'h0000_0140, 1'b1, 32'h0000_0060, "alias_new");
      // Not-taken miss on the same index must not allocate.
      update(32'h0000_0180, 1'b0, 32'h0000_0070, 1'b0);
      lookup(32'h0000_0140, 1'b1, 32'h0000_0060, "miss_nt_keep");
      lookup(32'h0000_0180, 1'b0, 32'h0000_0184, "miss_nt_noalloc");
   endtask

   task automatic test_wrap();
      @(negedge clk);
      br_EX = 1'b0; PC_EX = 32'hffff_fffc; br_taken_EX = 1'b1; predict_taken_EX = 1'b0;
      #1;
      total_cnt++;
      if (redirect_PC_EX !== 32'h0000_0000) $display("FAIL wrap_redirect: got %h expected 00000000", redirect_PC_EX);
      else pass_cnt++;
      total_cnt++;
      if (mispredict_EX !== 1'b0) $display("FAIL gated_mispredict: got %b expected 0", mispredict_EX);
      else pass_cnt++;
      @(negedge clk);
      br_EX = 1'b1; br_taken_EX = 1'b0; predict_taken_EX = 1'b0;
      #1;
      total_cnt++;
      if (redirect_PC_EX !== 32'h0000_0000) $display("FAIL wrap_nt_redirect: got %h expected 00000000", redirect_PC_EX);
      else pass_cnt++;
      total_cnt++;
      if (mispredict_EX !== 1'b0) $display("FAIL correct_nt_mispredict: got %b expected 0", mispredict_EX);
      else pass_cnt++;
      @(posedge clk);
`ifdef BRANCH_PREDICTOR_STATS_EN
      exp_br++;
`endif
      #1 br_EX = 1'b0;
   endtask

   task automatic test_same_cycle();
      @(negedge clk);
      PC_IF = 32'h0000_0200;
      PC_EX = 32'h0000_0200; br_taken_EX = 1'b1; br_target_EX = 32'h0000_0020; predict_taken_EX = 1'b0;
      br_EX = 1'b1;
      #1;
      total_cnt++;
      if (predict_taken_IF !== 1'b0) $display("FAIL same_cycle_pre: got %b expected 0", predict_taken_IF);
      else pass_cnt++;
      @(posedge clk);
`ifdef BRANCH_PREDICTOR_STATS_EN
      exp_br++; exp_misp++;
`endif
      #1 br_EX = 1'b0;
      lookup(32'h0000_0200, 1'b1, 32'h0000_0020, "same_cycle_post");
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      br_EX = 1'b1; br_taken_EX = 1'b1; predict_taken_EX = 1'b0;
      PC_EX = 32'h0000_0104; br_target_EX = 32'h0000_0500;
      @(negedge clk);
      PC_EX = 32'h0000_0108; br_target_EX = 32'h0000_0600;
      @(negedge clk);
      br_EX = 1'b0;
`ifdef BRANCH_PREDICTOR_STATS_EN
      exp_br += 2; exp_misp += 2;
`endif
      lookup(32'h0000_0104, 1'b1, 32'h0000_0500, "b2b_first");
      lookup(32'h0000_0108, 1'b1, 32'h0000_0600, "b2b_second");
   endtask

   task automatic test_async_reset();
      update(32'h0000_0100, 1'b1, 32'h0000_0044, 1'b0);
      lookup(32'h0000_0100, 1'b1, 32'h0000_0044, "pre_reset_hit");
`ifdef BRANCH_PREDICTOR_STATS_EN
      total_cnt++;
      if (br_count !== exp_br) $display("FAIL br_count: got %0d expected %0d", br_count, exp_br);
      else pass_cnt++;
      total_cnt++;
      if (mispredict_count !== exp_misp) $display("FAIL mispredict_count: got %0d expected %0d", mispredict_count, exp_misp);
      else pass_cnt++;
`endif
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if (predict_taken_IF !== 1'b0) $display("FAIL async_reset_taken: got %b expected 0", predict_taken_IF);
      else pass_cnt++;
      total_cnt++;
      if (predict_target_IF !== 32'h0000_0104) $display("FAIL async_reset_target: got %h expected 00000104", predict_target_IF);
      else pass_cnt++;
`ifdef BRANCH_PREDICTOR_STATS_EN
      total_cnt++;
      if (br_count !== 32'd0) $display("FAIL reset_br_count: got %0d expected 0", br_count);
      else pass_cnt++;
      total_cnt++;
      if (mispredict_count !== 32'd0) $display("FAIL reset_misp_count: got %0d expected 0", mispredict_count);
      else pass_cnt++;
`endif
      @(negedge clk);
      rst_n = 1'b1;
      lookup(32'h0000_0108, 1'b0, 32'h0000_010c, "post_reset_miss");
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_allocation();
      test_hysteresis();
      test_alias();
      test_wrap();
      test_same_cycle();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
